instr_mem_responder: RTL and testbench

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

---
 rtl/instr_mem_responder.sv | 144 ++++++++++++++
 tb/tb_instr_mem_responder.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// Instruction fetch responder: word memory behind a LATENCY-deep pipeline and 2-entry response FIFO (IMEM_MISALIGN_CHECK_EN adds misalignment faults).
// Latency: LATENCY cycles from accept to rsp_valid; program loads write at the clock edge.
// Backpressure: at most two fetches outstanding; req_ready drops at the credit limit, on req_flush and in reset.
module instr_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_flush,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_instr,
   output logic [31:0] rsp_addr,
   output logic        rsp_err,
   input  logic        ld_en,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef struct packed {
      logic        vld;
      logic        err;
      logic [31:0] addr;
      logic [31:0] instr;
   } stage_t;

   logic [31:0]   r_mem [DEPTH_WORDS];
   logic [1:0]    r_outstanding;
   stage_t        r_fifo [2];
   logic          r_wp;
   logic          r_rp;
   logic [1:0]    r_cnt;

   logic          w_accept;
   logic          w_pop;
   logic          w_oor;
   logic          w_err;
   logic [AW-1:0] w_rd_idx;
   stage_t        w_s0;
   stage_t        w_pout;
   stage_t        w_head;

   assign req_ready = reset && (r_outstanding < 2'd2) && !req_flush;
   assign w_accept  = req_valid && req_ready;
   assign w_pop     = rsp_valid && rsp_ready;
   assign w_oor     = req_addr[31:2] >= 30'(DEPTH_WORDS);
   assign w_rd_idx  = req_addr[AW+1:2];

`ifdef IMEM_MISALIGN_CHECK_EN
   assign w_err = w_oor || (req_addr[1:0] != 2'b00);
`else
   assign w_err = w_oor;
`endif

   // Read happens before this edge's load write lands, so a colliding read sees old data.
   always_comb begin
      w_s0       = '0;
      w_s0.vld   = w_accept;
      w_s0.err   = w_err;
      w_s0.addr  = req_addr;
      if (!w_err) begin
         w_s0.instr = r_mem[w_rd_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (ld_en && (ld_addr < 32'(DEPTH_WORDS))) begin
         r_mem[ld_addr[AW-1:0]] <= ld_data;
      end
   end

   // The response FIFO itself forms the final pipeline stage.
   generate
      if (LATENCY == 1) begin : g_nopipe
         assign w_pout = w_s0;
      end else begin : g_pipe
         stage_t r_pipe [LATENCY-1];

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < LATENCY-1; i++) r_pipe[i] <= '0;
            end else if (req_flush) begin
               for (int i = 0; i < LATENCY-1; i++) r_pipe[i] <= '0;
            end else begin
               r_pipe[0] <= w_s0;
               for (int i = 1; i < LATENCY-1; i++) r_pipe[i] <= r_pipe[i-1];
            end
         end

         assign w_pout = r_pipe[LATENCY-2];
      end
   endgenerate

   // Two credits guarantee the FIFO never overflows, so pushes are never refused.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wp      <= 1'b0;
         r_rp      <= 1'b0;
         r_cnt     <= 2'd0;
         r_fifo[0] <= '0;
         r_fifo[1] <= '0;
      end else if (req_flush) begin
         r_wp  <= 1'b0;
         r_rp  <= 1'b0;
         r_cnt <= 2'd0;
      end else begin
         if (w_pout.vld) begin
            r_fifo[r_wp] <= w_pout;
            r_wp         <= ~r_wp;
         end
         if (w_pop) begin
            r_rp <= ~r_rp;
         end
         r_cnt <= r_cnt + {1'b0, w_pout.vld} - {1'b0, w_pop};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_outstanding <= 2'd0;
      end else if (req_flush) begin
         r_outstanding <= 2'd0;
      end else begin
         case ({w_accept, w_pop})
            2'b10:   r_outstanding <= r_outstanding + 2'd1;
            2'b01:   r_outstanding <= r_outstanding - 2'd1;
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   assign w_head    = r_fifo[r_rp];
   assign rsp_valid = (r_cnt != 2'd0) && w_head.vld;
   assign rsp_instr = rsp_valid ? w_head.instr : 32'h0;
   assign rsp_addr  = rsp_valid ? w_head.addr  : 32'h0;
   assign rsp_err   = rsp_valid ? w_head.err   : 1'b0;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomized bench for instr_mem_responder against a queue-based reference model.
module tb_instr_mem_responder;

   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = 32'h0;
   logic        req_flush = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_instr;
   logic [31:0] rsp_addr;
   logic        rsp_err;
   logic        ld_en = 1'b0;
   logic [31:0] ld_addr = 32'h0;
   logic [31:0] ld_data = 32'h0;

   instr_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_flush(req_flush),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
      .rsp_addr(rsp_addr), .rsp_err(rsp_err),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] addr;
      logic [31:0] instr;
      logic        err;
   } exp_t;

   exp_t        q[$];
   logic [31:0] m_mem [DEPTH];
   int          now = 0;
   int          checks = 0;
   int          errors = 0;
   logic        e_ready, e_valid, e_err;
   logic [31:0] e_instr, e_addr;
   logic [31:0] got[$];

   function automatic exp_t predict(input logic [31:0] a, input int due);
      exp_t e;
      e.due  = due;
      e.addr = a;
      e.err  = (a[31:2] >= 30'(DEPTH));
`ifdef IMEM_MISALIGN_CHECK_EN
      if (a[1:0] != 2'b00) e.err = 1'b1;
`endif
      e.instr = e.err ? 32'h0 : m_mem[int'(a[31:2])];
      return e;
   endfunction

   // Called just before the rising edge: what the outputs must show this cycle.
   task automatic sample();
      #4;
      e_ready = (reset === 1'b1) && (q.size() < 2) && (req_flush !== 1'b1);
      e_valid = (reset === 1'b1) && (q.size() > 0) && (now >= q[0].due);
      e_instr = e_valid ? q[0].instr : 32'h0;
      e_addr  = e_valid ? q[0].addr  : 32'h0;
      e_err   = e_valid ? q[0].err   : 1'b0;
   endtask

   // Applies the events of the coming edge to the model, then moves to the next falling edge.
   task automatic commit();
      bit hs, acc;
      hs  = e_valid && (rsp_ready === 1'b1);
      acc = (req_valid === 1'b1) && e_ready;
      if (hs) got.push_back(rsp_instr);
      if (reset !== 1'b1 || req_flush === 1'b1) begin
         q.delete();
      end else begin
         if (hs) void'(q.pop_front());
         if (acc) q.push_back(predict(req_addr, now + LAT));
      end
      if (ld_en === 1'b1 && ld_addr < DEPTH) m_mem[int'(ld_addr)] = ld_data;
      @(negedge clk);
      now++;
   endtask

   task automatic test_reset();
      req_valid = 1'b1;
      req_addr  = 32'h0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sample();
         checks++;
         if ({req_ready, rsp_valid, rsp_err, rsp_instr, rsp_addr} !== 67'h0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b v=%b e=%b i=%h a=%h exp all zero",
                     req_ready, rsp_valid, rsp_err, rsp_instr, rsp_addr);
         end
         commit();
      end
      reset     = 1'b1;
      req_valid = 1'b0;
      sample();
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got rdy=%b v=%b exp rdy=1 v=0", req_ready, rsp_valid);
      end
      commit();
   endtask

   task automatic test_load();
      for (int i = 0; i < DEPTH; i++) begin
         ld_en   = 1'b1;
         ld_addr = i;
         ld_data = (i < 4) ? 32'((i + 1) * 32'h11) : $urandom;
         sample();
         checks++;
         if (rsp_valid !== e_valid || req_ready !== e_ready) begin
            errors++;
            $display("FAIL load t=%0d got v=%b r=%b exp v=%b r=%b", now, rsp_valid, req_ready, e_valid, e_ready);
         end
         commit();
      end
      ld_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      int n = 0, acc0 = -1, v0 = -1;
      got.delete();
      rsp_ready = 1'b1;
      for (int c = 0; c < 14; c++) begin
         req_valid = (n < 4);
         req_addr  = 32'(n * 4);
         sample();
         checks++;
         if (rsp_valid !== e_valid || req_ready !== e_ready ||
             (e_valid && (rsp_instr !== e_instr || rsp_addr !== e_addr || rsp_err !== e_err))) begin
            errors++;
            $display("FAIL back_to_back t=%0d got v=%b r=%b i=%h a=%h e=%b exp v=%b r=%b i=%h a=%h e=%b",
                     now, rsp_valid, req_ready, rsp_instr, rsp_addr, rsp_err, e_valid, e_ready, e_instr, e_addr, e_err);
         end
         if (rsp_valid === 1'b1 && v0 < 0) v0 = now;
         if (req_valid && e_ready) begin
            if (n == 0) acc0 = now;
            n++;
         end
         commit();
      end
      req_valid = 1'b0;
      checks++;
      if (v0 - acc0 != LAT) begin
         errors++;
         $display("FAIL first_latency got %0d exp %0d", v0 - acc0, LAT);
      end
      checks++;
      if (got.size() != 4 || got[0] !== 32'h11 || got[1] !== 32'h22 || got[2] !== 32'h33 || got[3] !== 32'h44) begin
         errors++;
         $display("FAIL b2b_order got %0d responses exp 11,22,33,44", got.size());
      end
   endtask

   task automatic test_backpressure();
      int n = 0;
      got.delete();
      rsp_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         req_valid = 1'b1;
         req_addr  = 32'(n * 4);
         sample();
         checks++;
         if (rsp_valid !== e_valid || req_ready !== e_ready ||
             (e_valid && (rsp_instr !== e_instr || rsp_addr !== e_addr || rsp_err !== e_err))) begin
            errors++;
            $display("FAIL backpressure t=%0d got v=%b r=%b i=%h exp v=%b r=%b i=%h",
                     now, rsp_valid, req_ready, rsp_instr, e_valid, e_ready, e_instr);
         end
         if (e_ready) n++;
         commit();
      end
      req_valid = 1'b0;
      #4;
      checks++;
      if (n != 2 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL credit_limit got accepted=%0d rdy=%b exp accepted=2 rdy=0", n, req_ready);
      end
      @(negedge clk);
      now++;
      rsp_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         sample();
         checks++;
         if (rsp_valid !== e_valid || req_ready !== e_ready ||
             (e_valid && (rsp_instr !== e_instr || rsp_addr !== e_addr || rsp_err !== e_err))) begin
            errors++;
            $display("FAIL bp_drain t=%0d got v=%b r=%b i=%h exp v=%b r=%b i=%h",
                     now, rsp_valid, req_ready, rsp_instr, e_valid, e_ready, e_instr);
         end
         commit();
      end
      checks++;
      if (got.size() != 2 || got[0] !== 32'h11 || got[1] !== 32'h22 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release got n=%0d rdy=%b exp n=2 rdy=1", got.size(), req_ready);
      end
   endtask

   task automatic test_out_of_range();
      logic [31:0] addrs [4];
      addrs[0] = 32'h400;
      addrs[1] = 32'hFFFF_FFFC;
      addrs[2] = {30'($urandom_range(DEPTH, 4 * DEPTH)), 2'b00};
      addrs[3] = 32'h3FC;
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < LAT + 2; c++) begin
            req_valid = (c == 0);
            req_addr  = addrs[k];
            sample();
            checks++;
            if (rsp_valid !== e_valid || req_ready !== e_ready ||
                (e_valid && (rsp_instr !== e_instr || rsp_addr !== e_addr || rsp_err !== e_err))) begin
               errors++;
               $display("FAIL out_of_range t=%0d got v=%b i=%h a=%h e=%b exp v=%b i=%h a=%h e=%b",
                        now, rsp_valid, rsp_instr, rsp_addr, rsp_err, e_valid, e_instr, e_addr, e_err);
            end
            commit();
         end
      end
      req_valid = 1'b0;
   endtask

   task automatic test_flush();
      got.delete();
      rsp_ready = 1'b0;
      for (int c = 0; c < 12; c++) begin
         req_valid = (c < 2) || (c == 4);
         req_addr  = (c == 4) ? 32'h8 : 32'(c * 4);
         req_flush = (c == 2);
         rsp_ready = (c >= 3);
         sample();
         checks++;
         if (rsp_valid !== e_valid || req_ready !== e_ready || (c == 3 && rsp_valid !== 1'b0) ||
             (e_valid && (rsp_instr !== e_instr || rsp_addr !== e_addr || rsp_err !== e_err))) begin
            errors++;
            $display("FAIL flush t=%0d got v=%b r=%b i=%h exp v=%b r=%b i=%h",
                     now, rsp_valid, req_ready, rsp_instr, e_valid, e_ready, e_instr);
         end
         commit();
      end
      req_valid = 1'b0;
      req_flush = 1'b0;
      checks++;
      if (got.size() != 1 || got[0] !== 32'h33) begin
         errors++;
         $display("FAIL flush_next got n=%0d exp one response 33", got.size());
      end
   endtask

   task automatic test_load_collision();
      got.delete();
      rsp_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         req_valid = (c < 2);
         req_addr  = 32'h4;
         ld_en     = (c == 0);
         ld_addr   = 32'h1;
         ld_data   = 32'hAA;
         sample();
         checks++;
         if (rsp_valid !== e_valid || req_ready !== e_ready ||
             (e_valid && (rsp_instr !== e_instr || rsp_addr !== e_addr || rsp_err !== e_err))) begin
            errors++;
            $display("FAIL load_collision t=%0d got v=%b i=%h exp v=%b i=%h", now, rsp_valid, rsp_instr, e_valid, e_instr);
         end
         commit();
      end
      req_valid = 1'b0;
      ld_en     = 1'b0;
      checks++;
      if (got.size() != 2 || got[0] !== 32'h22 || got[1] !== 32'hAA) begin
         errors++;
         $display("FAIL collision_order got n=%0d exp 22 then AA", got.size());
      end
   endtask

   task automatic test_misalign();
      logic [31:0] want;
      got.delete();
`ifdef IMEM_MISALIGN_CHECK_EN
      want = 32'h0;
`else
      want = 32'hAA;
`endif
      rsp_ready = 1'b1;
      for (int c = 0; c < LAT + 2; c++) begin
         req_valid = (c == 0);
         req_addr  = 32'h6;
         sample();
         checks++;
         if (rsp_valid !== e_valid || req_ready !== e_ready ||
             (e_valid && (rsp_instr !== e_instr || rsp_addr !== e_addr || rsp_err !== e_err))) begin
            errors++;
            $display("FAIL misalign t=%0d got v=%b i=%h e=%b exp v=%b i=%h e=%b",
                     now, rsp_valid, rsp_instr, rsp_err, e_valid, e_instr, e_err);
         end
         commit();
      end
      req_valid = 1'b0;
      checks++;
      if (got.size() != 1 || got[0] !== want) begin
         errors++;
         $display("FAIL misalign_word got n=%0d exp one response %h", got.size(), want);
      end
   endtask

   task automatic test_reset_midflight();
      int seen = 0;
      for (int c = 0; c < 10; c++) begin
         req_valid = (c < 2);
         req_addr  = 32'(c * 4);
         rsp_ready = (c >= 4);
         reset     = !(c == 2 || c == 3);
         sample();
         if (rsp_valid === 1'b1) seen++;
         checks++;
         if (rsp_valid !== e_valid || req_ready !== e_ready) begin
            errors++;
            $display("FAIL reset_midflight t=%0d got v=%b r=%b exp v=%b r=%b", now, rsp_valid, req_ready, e_valid, e_ready);
         end
         commit();
      end
      req_valid = 1'b0;
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL reset_drop got %0d valid cycles exp 0", seen);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 9))
            0:       req_addr = {30'($urandom_range(DEPTH, DEPTH + 64)), 2'b00};
            1:       req_addr = 32'hFFFF_FFFC;
            2:       req_addr = {30'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
            default: req_addr = {30'($urandom_range(0, DEPTH - 1)), 2'b00};
         endcase
         rsp_ready = ($urandom_range(0, 9) < 7);
         req_flush = ($urandom_range(0, 19) == 0);
         ld_en     = ($urandom_range(0, 4) == 0);
         ld_addr   = 32'($urandom_range(0, DEPTH + 8));
         ld_data   = $urandom;
         sample();
         checks++;
         if (rsp_valid !== e_valid || req_ready !== e_ready ||
             (e_valid && (rsp_instr !== e_instr || rsp_addr !== e_addr || rsp_err !== e_err))) begin
            errors++;
            $display("FAIL random t=%0d got v=%b r=%b i=%h a=%h e=%b exp v=%b r=%b i=%h a=%h e=%b",
                     now, rsp_valid, req_ready, rsp_instr, rsp_addr, rsp_err, e_valid, e_ready, e_instr, e_addr, e_err);
         end
         commit();
      end
      req_valid = 1'b0;
      req_flush = 1'b0;
      ld_en     = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_load();
      test_back_to_back();
      test_backpressure();
      test_out_of_range();
      test_flush();
      test_load_collision();
      test_misalign();
      test_reset_midflight();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
